// File: rtl/hcp_port_stat_pkg.sv
// Shared constants for the per-port packet statistics engine: FSM state
// encodings, the counter-type order within a port, and report layout.
package hcp_stat_defs;

  // Report FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;

  // Order of the three counters belonging to one port (also report order)
  localparam int CT_IN   = 0;
  localparam int CT_DISC = 1;
  localparam int CT_OUT  = 2;
  localparam int CT_NUM  = 3;

  // Header layout: port count first, then the sequence number
  localparam int HDR_NPORTS_OFS = 0;
  localparam int HDR_SEQ_OFS    = 1;
  localparam int HDR_BYTES      = 2;

  // Total report length in bytes for a given port count and counter width
  function automatic int report_bytes(input int num_ports, input int cnt_w);
    return HDR_BYTES + CT_NUM * num_ports * (cnt_w / 8);
  endfunction

endpackage

// File: rtl/hcp_port_stat_counter.sv
// One live event counter plus its snapshot register. The live count can wrap
// or saturate, and may be cleared when the snapshot is taken without losing
// an event that arrives in the same cycle.
module hcp_stat_counter #(
  parameter int CNT_W       = 32,
  parameter int SAT_MODE    = 0,
  parameter int CLR_ON_READ = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  input  logic             snap_i,
  output logic [CNT_W-1:0] snap_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] snap_q, snap_d;
  logic [CNT_W-1:0] inc_val;

  // Next live count: explicit clear beats snapshot-clear beats increment
  always_comb begin
    if ((SAT_MODE != 0) && (cnt_q == '1)) inc_val = cnt_q;
    else                                  inc_val = cnt_q + CNT_W'(1);

    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (snap_i && (CLR_ON_READ != 0)) begin
      // The event arriving with the snapshot belongs to the next interval
      cnt_d = inc_i ? CNT_W'(1) : '0;
    end else if (inc_i) begin
      cnt_d = inc_val;
    end

    // Snapshot holds the count as it stood before this cycle's event
    snap_d = snap_i ? cnt_q : snap_q;
  end

  // Live counter and snapshot registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q  <= '0;
      snap_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      snap_q <= snap_d;
    end
  end

  assign snap_o = snap_q;

endmodule

// File: rtl/hcp_port_stat.sv
// Per-port packet statistics engine. Counts inpkt/discard/outpkt pulses for
// every port, snapshots all counters on the report trigger and streams the
// snapshot out as a byte report after a req/ack handshake.
module hcp_port_stat
  import hcp_stat_defs::*;
#(
  parameter int NUM_PORTS   = 5,
  parameter int CNT_W       = 32,
  parameter int SAT_MODE    = 0,
  parameter int CLR_ON_READ = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NUM_PORTS-1:0] iv_inpkt_pulse,
  input  logic [NUM_PORTS-1:0] iv_discard_pkt_pulse,
  input  logic [NUM_PORTS-1:0] iv_outpkt_pulse,
  input  logic                 i_stat_clr,
  input  logic                 i_report_pulse,
  output logic                 o_report_req,
  input  logic                 i_report_ack,
  output logic [7:0]           ov_report_data,
  output logic                 o_report_data_wr,
  output logic                 o_report_data_last,
  output logic                 o_report_drop_pulse
);

  localparam int NCNT   = CT_NUM * NUM_PORTS;
  localparam int BPC    = CNT_W / 8;
  localparam int NBYTES = report_bytes(NUM_PORTS, CNT_W);
  localparam int IDX_W  = $clog2(NBYTES);
  localparam int CTR_W  = $clog2(NCNT);
  localparam int BSEL_W = (BPC > 1) ? $clog2(BPC) : 1;

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;     // byte position within the report
  logic [CTR_W-1:0]  ctr_q, ctr_d;     // counter currently being sent
  logic [BSEL_W-1:0] bsel_q, bsel_d;   // byte of that counter, counts down (MSB first)
  logic [7:0]        seq_q, seq_d;     // live sequence number
  logic [7:0]        rpt_seq_q, rpt_seq_d; // sequence number frozen with the snapshot
  logic              drop_q, drop_d;
  logic              snap_take;

  logic [CNT_W-1:0]  snap_arr [NCNT];

  assign snap_take = (state_q == ST_IDLE) && i_report_pulse;

  // Counter bank: three counters per port, ordered IN, DISC, OUT
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [CT_NUM-1:0] inc_v;
    assign inc_v[CT_IN]   = iv_inpkt_pulse[p];
    assign inc_v[CT_DISC] = iv_discard_pkt_pulse[p];
    assign inc_v[CT_OUT]  = iv_outpkt_pulse[p];
    for (genvar t = 0; t < CT_NUM; t++) begin : g_type
      hcp_stat_counter #(
        .CNT_W      (CNT_W),
        .SAT_MODE   (SAT_MODE),
        .CLR_ON_READ(CLR_ON_READ)
      ) u_cnt (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .inc_i  (inc_v[t]),
        .clr_i  (i_stat_clr),
        .snap_i (snap_take),
        .snap_o (snap_arr[p*CT_NUM+t])
      );
    end
  end

  // Report FSM, byte walker and sequence number
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ctr_d     = ctr_q;
    bsel_d    = bsel_q;
    seq_d     = seq_q;
    rpt_seq_d = snap_take ? seq_q : rpt_seq_q;
    drop_d    = i_report_pulse && (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (i_report_pulse) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (i_report_ack) begin
          state_d = ST_SEND;
          idx_d   = '0;
          ctr_d   = '0;
          bsel_d  = BSEL_W'(BPC - 1);
        end
      end
      ST_SEND: begin
        if (idx_q == IDX_W'(NBYTES - 1)) begin
          state_d = ST_IDLE;
          seq_d   = seq_q + 8'd1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
          // Header bytes do not advance the counter walker
          if (idx_q >= IDX_W'(HDR_BYTES)) begin
            if (bsel_q == '0) begin
              bsel_d = BSEL_W'(BPC - 1);
              ctr_d  = ctr_q + CTR_W'(1);
            end else begin
              bsel_d = bsel_q - BSEL_W'(1);
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A clear wins over the end-of-report increment
    if (i_stat_clr) seq_d = '0;
  end

  // FSM and report-path state registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      ctr_q     <= '0;
      bsel_q    <= '0;
      seq_q     <= '0;
      rpt_seq_q <= '0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ctr_q     <= ctr_d;
      bsel_q    <= bsel_d;
      seq_q     <= seq_d;
      rpt_seq_q <= rpt_seq_d;
      drop_q    <= drop_d;
    end
  end

  // Output decode straight from state so a reset drops everything at once
  always_comb begin
    o_report_req       = (state_q == ST_REQ);
    o_report_data_wr   = (state_q == ST_SEND);
    o_report_data_last = (state_q == ST_SEND) && (idx_q == IDX_W'(NBYTES - 1));
    ov_report_data     = '0;
    if (state_q == ST_SEND) begin
      if (idx_q == IDX_W'(HDR_NPORTS_OFS))   ov_report_data = 8'(NUM_PORTS);
      else if (idx_q == IDX_W'(HDR_SEQ_OFS)) ov_report_data = rpt_seq_q;
      else ov_report_data = snap_arr[ctr_q][{bsel_q, 3'b000} +: 8];
    end
  end

  assign o_report_drop_pulse = drop_q;

endmodule

// File: tb/tb_hcp_port_stat.sv
// Directed bench for hcp_port_stat: default-parameter instance for protocol,
// counting, clear and reset behaviour, plus two 8-bit instances for
// wrap versus saturate.
module tb_hcp_port_stat;

  localparam int NP = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [NP-1:0] inpkt, disc, outpkt;
  logic          stat_clr, rpt_pulse, ack;
  logic          req, wr, last, drop;
  logic [7:0]    data;

  logic [NP-1:0] sm_in, zero_v;
  logic          sm_pulse, sm_ack, zero_b;
  logic          w_req, w_wr, w_last, w_drop;
  logic          s_req, s_wr, s_last, s_drop;
  logic [7:0]    w_data, s_data;

  hcp_port_stat #(.NUM_PORTS(NP), .CNT_W(32), .SAT_MODE(0), .CLR_ON_READ(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .iv_inpkt_pulse(inpkt), .iv_discard_pkt_pulse(disc), .iv_outpkt_pulse(outpkt),
    .i_stat_clr(stat_clr), .i_report_pulse(rpt_pulse),
    .o_report_req(req), .i_report_ack(ack),
    .ov_report_data(data), .o_report_data_wr(wr), .o_report_data_last(last),
    .o_report_drop_pulse(drop)
  );

  hcp_port_stat #(.NUM_PORTS(NP), .CNT_W(8), .SAT_MODE(0), .CLR_ON_READ(1)) dut_w (
    .i_clk(clk), .i_rst_n(rst_n),
    .iv_inpkt_pulse(sm_in), .iv_discard_pkt_pulse(zero_v), .iv_outpkt_pulse(zero_v),
    .i_stat_clr(zero_b), .i_report_pulse(sm_pulse),
    .o_report_req(w_req), .i_report_ack(sm_ack),
    .ov_report_data(w_data), .o_report_data_wr(w_wr), .o_report_data_last(w_last),
    .o_report_drop_pulse(w_drop)
  );

  hcp_port_stat #(.NUM_PORTS(NP), .CNT_W(8), .SAT_MODE(1), .CLR_ON_READ(1)) dut_s (
    .i_clk(clk), .i_rst_n(rst_n),
    .iv_inpkt_pulse(sm_in), .iv_discard_pkt_pulse(zero_v), .iv_outpkt_pulse(zero_v),
    .i_stat_clr(zero_b), .i_report_pulse(sm_pulse),
    .o_report_req(s_req), .i_report_ack(sm_ack),
    .ov_report_data(s_data), .o_report_data_wr(s_wr), .o_report_data_last(s_last),
    .o_report_drop_pulse(s_drop)
  );

  // Byte collectors
  logic [7:0] rx[$], wq[$], sq[$];
  bit         rxl[$], wql[$], sql[$];
  always @(negedge clk) if (wr === 1'b1)   begin rx.push_back(data);   rxl.push_back(last);   end
  always @(negedge clk) if (w_wr === 1'b1) begin wq.push_back(w_data); wql.push_back(w_last); end
  always @(negedge clk) if (s_wr === 1'b1) begin sq.push_back(s_data); sql.push_back(s_last); end

  int n_chk = 0;
  int n_err = 0;
  int unsigned expc [NP*3];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clr_exp();
    foreach (expc[i]) expc[i] = 0;
  endtask

  // kind: 0 = inpkt, 1 = discard, 2 = outpkt
  task automatic pulse_in(input int port, input int kind, input int n);
    repeat (n) begin
      @(posedge clk); #1;
      case (kind)
        0:       inpkt[port]  = 1'b1;
        1:       disc[port]   = 1'b1;
        default: outpkt[port] = 1'b1;
      endcase
      @(posedge clk); #1;
      inpkt = '0; disc = '0; outpkt = '0;
    end
  endtask

  // Trigger a report and ack it; returns at the negedge showing byte 0
  task automatic start_report(input int ack_dly, input logic [NP-1:0] co_out, input bit clr_in_req);
    rx.delete(); rxl.delete();
    @(negedge clk);
    chk("req_pre", req, 1'b0);
    @(posedge clk); #1;
    rpt_pulse = 1'b1; outpkt = co_out;
    @(posedge clk); #1;
    rpt_pulse = 1'b0; outpkt = '0;
    @(negedge clk);
    chk("req_rise", req, 1'b1);
    chk("drop_idle", drop, 1'b0);
    if (clr_in_req) begin
      @(posedge clk); #1;
      stat_clr = 1'b1; inpkt[3] = 1'b1; outpkt[4] = 1'b1;
      @(posedge clk); #1;
      stat_clr = 1'b0; inpkt = '0; outpkt = '0;
    end
    repeat (ack_dly) begin @(posedge clk); #1; end
    ack = 1'b1;
    @(negedge clk);
    chk("req_hold", req, 1'b1);
    @(posedge clk); #1;
    ack = 1'b0;
    @(negedge clk);
    chk("req_fall", req, 1'b0);
    chk("wr_first", wr, 1'b1);
    chk("byte0_now", data, 8'd5);
  endtask

  task automatic finish_report();
    int cyc = 0;
    bit req_seen = 1'b0;
    while (!(wr === 1'b1 && last === 1'b1) && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (req === 1'b1) req_seen = 1'b1;
    end
    chk("last_timeout", (cyc < 500), 1'b1);
    chk("req_in_send", req_seen, 1'b0);
    @(posedge clk); #1;
  endtask

  // Compare the collected report against expc[] and the expected sequence
  task automatic check_report(input string nm, input int seq_exp);
    int nl = 0;
    chk({nm, "_len"}, rx.size(), 62);
    if (rx.size() == 62) begin
      chk({nm, "_b0"}, rx[0], 8'h05);
      if (seq_exp >= 0) chk({nm, "_seq"}, rx[1], seq_exp[7:0]);
      for (int c = 0; c < NP*3; c++)
        for (int b = 0; b < 4; b++)
          chk($sformatf("%s_c%0d_b%0d", nm, c, b), rx[2+4*c+b], (expc[c] >> (8*(3-b))) & 32'hFF);
      foreach (rxl[i]) if (rxl[i]) nl++;
      chk({nm, "_last_cnt"}, nl, 1);
      chk({nm, "_last_pos"}, rxl[61], 1'b1);
    end
  endtask

  task automatic check_small(input string nm, input logic [7:0] q[$], input bit ql[$], input logic [7:0] exp_c0);
    chk({nm, "_len"}, q.size(), 17);
    if (q.size() == 17) begin
      chk({nm, "_b0"}, q[0], 8'h05);
      chk({nm, "_seq"}, q[1], 8'h00);
      chk({nm, "_p0_in"}, q[2], exp_c0);
      for (int i = 3; i < 17; i++) chk($sformatf("%s_b%0d", nm, i), q[i], 8'h00);
      chk({nm, "_last_pos"}, ql[16], 1'b1);
      chk({nm, "_last_early"}, ql[15], 1'b0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; inpkt = '0; disc = '0; outpkt = '0;
    stat_clr = 1'b0; rpt_pulse = 1'b0; ack = 1'b0;
    sm_in = '0; zero_v = '0; sm_pulse = 1'b0; sm_ack = 1'b0; zero_b = 1'b0;
    clr_exp();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", req, 1'b0);
    chk("rst_wr", wr, 1'b0);
    chk("rst_last", last, 1'b0);
    chk("rst_data", data, 8'h00);
    chk("rst_drop", drop, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic report after reset
    pulse_in(2, 0, 3);
    pulse_in(0, 1, 1);
    start_report(4, '0, 1'b0);
    finish_report();
    expc[1] = 1; expc[6] = 3;
    check_report("r1", 0);

    // Event coincident with the trigger lands in the next interval
    clr_exp();
    start_report(2, 5'b00010, 1'b0);
    finish_report();
    check_report("r2", 1);
    start_report(2, '0, 1'b0);
    finish_report();
    expc[5] = 1;
    check_report("r3", 2);

    // Trigger while sending is dropped and clears nothing
    clr_exp();
    pulse_in(0, 0, 2);
    start_report(1, '0, 1'b0);
    @(posedge clk); #1; inpkt[0] = 1'b1;
    @(posedge clk); #1; inpkt = '0; rpt_pulse = 1'b1;
    @(posedge clk); #1; rpt_pulse = 1'b0;
    @(negedge clk); chk("drop_on", drop, 1'b1);
    @(negedge clk); chk("drop_off", drop, 1'b0);
    finish_report();
    expc[0] = 2;
    check_report("r4", 3);
    @(negedge clk); chk("req_after_drop", req, 1'b0);
    start_report(1, '0, 1'b0);
    finish_report();
    expc[0] = 1;
    check_report("r5", 4);

    // Clear with coincident pulses while in REQ
    clr_exp();
    pulse_in(3, 0, 1);
    pulse_in(4, 2, 1);
    start_report(10, '0, 1'b1);
    finish_report();
    expc[9] = 1; expc[14] = 1;
    check_report("r6", -1);
    clr_exp();
    start_report(1, '0, 1'b0);
    finish_report();
    check_report("r7", 1);

    // Asynchronous reset in the middle of a report
    pulse_in(1, 1, 2);
    start_report(1, '0, 1'b0);
    repeat (20) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_wr", wr, 1'b0);
    chk("arst_last", last, 1'b0);
    chk("arst_req", req, 1'b0);
    chk("arst_data", data, 8'h00);
    chk("arst_partial_len", rx.size(), 21);
    begin
      int nl = 0;
      foreach (rxl[i]) if (rxl[i]) nl++;
      chk("arst_no_last", nl, 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    clr_exp();
    start_report(3, '0, 1'b0);
    finish_report();
    check_report("r9", 0);

    // 8-bit counters: 257 events wrap to 1 or saturate at 0xFF
    @(posedge clk); #1;
    sm_in[0] = 1'b1;
    repeat (257) @(posedge clk);
    #1 sm_in = '0;
    wq.delete(); wql.delete(); sq.delete(); sql.delete();
    @(posedge clk); #1 sm_pulse = 1'b1;
    @(posedge clk); #1 sm_pulse = 1'b0;
    @(negedge clk);
    chk("sm_req_w", w_req, 1'b1);
    chk("sm_req_s", s_req, 1'b1);
    @(posedge clk); #1 sm_ack = 1'b1;
    @(posedge clk); #1 sm_ack = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check_small("wrap", wq, wql, 8'h01);
    check_small("sat", sq, sql, 8'hFF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/hcp_port_stat.md
Name: hcp_port_stat

Overview:
Parametrised per-port packet statistics engine for the hardware control point. It replaces the fixed 5-port pulse counting inside configuration state management.
- Counts inpkt, discard and outpkt pulses for NUM_PORTS ports.
- Snapshots all counters on the report pulse.
- Streams the snapshot as a byte report to the frame-parse report path, using a req/ack handshake.
- Optionally clears counters on read and optionally saturates instead of wrapping.

Parameters:
NUM_PORTS, 5, number of ports counted (1..16)
CNT_W, 32, counter width in bits; multiple of 8, range 8..64
SAT_MODE, 0, 0 = counters wrap to 0 after all-ones; 1 = counters hold at all-ones
CLR_ON_READ, 1, 1 = live counters cleared when snapshot is taken; 0 = free-running

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  reset, asynchronous, active-low
iv_inpkt_pulse  in  NUM_PORTS  one-cycle pulse per received packet, bit n = port n
iv_discard_pkt_pulse  in  NUM_PORTS  one-cycle pulse per discarded packet
iv_outpkt_pulse  in  NUM_PORTS  one-cycle pulse per transmitted packet
i_stat_clr  in  1  synchronous clear of live counters and sequence number
i_report_pulse  in  1  report trigger (1 s pulse from global time sync)
o_report_req  out  1  report request to frame-parse path
i_report_ack  in  1  grant from frame-parse path
ov_report_data  out  8  report byte
o_report_data_wr  out  1  byte valid
o_report_data_last  out  1  marks final report byte
o_report_drop_pulse  out  1  one-cycle pulse: trigger ignored because block busy

Behaviour:
- Reset values: all counters, snapshots and the sequence number are 0; state is IDLE; all outputs are 0.
- Counters: 3*NUM_PORTS live counters, each CNT_W bits. Each pulse increments its counter by 1 on the same edge.
  - SAT_MODE=0: all-ones+1 wraps to 0.
  - SAT_MODE=1: the counter holds at all-ones.
- Live-counter priority on any cycle: i_stat_clr > snapshot-clear > increment.
  - i_stat_clr=1 forces 0, even if a pulse arrives in the same cycle.
  - Snapshot with CLR_ON_READ=1: the counter loads 1 if its pulse arrives in the same cycle, else 0. No event is lost.
  - Snapshot with CLR_ON_READ=0: the counter keeps counting normally.
- Snapshot: when i_report_pulse=1 in IDLE, snapshot registers capture the live counter values before that cycle's increment. State moves to REQ.
- FSM states:
  - IDLE: waits for i_report_pulse.
  - REQ: o_report_req=1 from the cycle after the trigger. It holds until i_report_ack is sampled high.
  - SEND: entered on the edge after ack. o_report_req drops on that edge, and the first byte is valid the same cycle (latency ack to byte0 = 1 cycle). Exactly one byte is sent per cycle with no gaps; the downstream path does not back-pressure.
  - Return to IDLE the cycle after the last byte.
- Report format: N = 2 + 3*NUM_PORTS*CNT_W/8 bytes (62 for defaults).
  - byte0 = NUM_PORTS.
  - byte1 = 8-bit sequence number.
  - Then for port 0..NUM_PORTS-1: inpkt, discard, outpkt counters, each MSB byte first.
  - o_report_data_last=1 only with byte N-1. The sequence number increments (mod 256) on the last byte.
- Trigger while not IDLE: no snapshot, no counter clear, o_report_drop_pulse=1 for one cycle.
- i_stat_clr while in REQ/SEND: live counters and sequence number clear; the in-flight report continues from the snapshot unchanged. A clear during the last-byte cycle wins over the sequence increment.
- i_report_ack while in IDLE or SEND: ignored.
- Asynchronous reset mid-report: all outputs drop to 0 immediately and the FSM returns to IDLE. No partial last is generated.

Decomposition:
- Shared include/package hcp_stat_defs:
  - FSM state encodings (IDLE, REQ, SEND).
  - Per-port counter-type order constants (IN=0, DISC=1, OUT=2).
  - Report byte-count expression and header byte offsets.
- One sub-module, hcp_stat_counter: single CNT_W counter with inc, clr, snap-clear, SAT_MODE, and a snapshot register. It is instantiated 3*NUM_PORTS times via generate.
- The top holds the FSM, byte index counter and output mux.

Test Plan:
- Reset, defaults: 3 inpkt pulses on port2, 1 discard on port0, then report, ack 4 cycles after req.
  - Expect req high 1 cycle after trigger and low 1 cycle after ack.
  - Expect 62 bytes: byte0=0x05, byte1=0x00.
  - Port0 discard = 00 00 00 01; port2 inpkt = 00 00 00 03.
  - last only on byte 61; live counters are 0 afterwards.
- Pulse on port1 outpkt in the same cycle as the trigger, CLR_ON_READ=1.
  - Snapshot value 0 for that counter; live counter = 1; next report shows 1.
- CNT_W=8, SAT_MODE=0 vs 1: 257 pulses on port0 inpkt.
  - Wrap mode reports 0x01; saturate mode reports 0xFF; report length = 2+15 = 17 bytes.
- Second trigger during SEND: o_report_drop_pulse one cycle, counters not cleared, no new req until IDLE; the next report sequence byte = previous+1.
- i_stat_clr with simultaneous pulses during REQ: in-flight report bytes equal the pre-clear snapshot; live counters are 0; ack arriving 10 cycles later still yields a full report.
- Assert i_rst_n low at byte 20 of SEND: data_wr, last and req go to 0 immediately; after release a new trigger produces a full report with sequence byte 0x00.
